// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: bundle of both requester ports and the data-memory port
//   a_*/b_*  : req, we, addr, wdata in; gnt, rvalid, rdata, err out (per port)
//   mem_*    : addr, wdata, write, read out; rdata in
interface dmem_arbiter_if;
  logic        a_req, a_we, a_gnt, a_rvalid, a_err;
  logic [63:0] a_addr, a_wdata, a_rdata;
  logic        b_req, b_we, b_gnt, b_rvalid, b_err;
  logic [63:0] b_addr, b_wdata, b_rdata;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_write, mem_read;
  modport slave (
    input  a_req, a_we, a_addr, a_wdata, b_req, b_we, b_addr, b_wdata, mem_rdata,
    output a_gnt, a_rvalid, a_err, a_rdata, b_gnt, b_rvalid, b_err, b_rdata,
           mem_addr, mem_wdata, mem_write, mem_read
  );
  modport master (
    output a_req, a_we, a_addr, a_wdata, b_req, b_we, b_addr, b_wdata, mem_rdata,
    input  a_gnt, a_rvalid, a_err, a_rdata, b_gnt, b_rvalid, b_err, b_rdata,
           mem_addr, mem_wdata, mem_write, mem_read
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port round-robin sequencer for a 64-bit byte-addressed data memory
//   clk, reset_n : clock, synchronous active-low reset
//   bus          : requester ports A/B and memory port (dmem_arbiter_if.slave)
module dmem_arbiter #(
  parameter int MEM_BYTES = 256
) (
  input logic           clk,
  input logic           reset_n,
  dmem_arbiter_if.slave bus
);
  localparam logic [63:0] LAST_ADDR = 64'(MEM_BYTES - 8);
  typedef enum logic [1:0] {IDLE, SERVE_A, SERVE_B} state_t;
  state_t      r_state, w_next;
  logic        r_last_b, r_cur_we, r_cur_err;
  logic [63:0] r_cur_addr, r_cur_wdata;
  logic        r_a_rvalid, r_a_err, r_b_rvalid, r_b_err;
  logic [63:0] r_a_rdata, r_b_rdata;
  logic        w_sel_b, w_serve, w_a_resp, w_b_resp, w_we;
  logic [63:0] w_addr, w_wdata;
  // on a tie the port not granted last wins; r_last_b resets to 1 so A wins first
  always_comb begin
    w_next = (bus.a_req & bus.b_req) ? (r_last_b ? SERVE_A : SERVE_B) :
             bus.a_req ? SERVE_A : bus.b_req ? SERVE_B : IDLE;
    w_sel_b = w_next == SERVE_B;
    w_we = w_sel_b ? bus.b_we : bus.a_we;
    w_addr = w_sel_b ? bus.b_addr : bus.a_addr;
    w_wdata = w_sel_b ? bus.b_wdata : bus.a_wdata;
    w_serve = r_state != IDLE;
    w_a_resp = (r_state == SERVE_A) & (r_cur_err | ~r_cur_we);
    w_b_resp = (r_state == SERVE_B) & (r_cur_err | ~r_cur_we);
    bus.a_gnt = r_state == SERVE_A;
    bus.b_gnt = r_state == SERVE_B;
    bus.mem_addr = w_serve ? r_cur_addr : '0;
    bus.mem_wdata = w_serve ? r_cur_wdata : '0;
    // reset_n gates the write so a reset during SERVE leaves memory untouched
    bus.mem_write = w_serve & r_cur_we & ~r_cur_err & reset_n;
    bus.mem_read = w_serve & ~r_cur_we & ~r_cur_err;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_last_b <= 1'b1;
      r_cur_we <= 1'b0;
      r_cur_err <= 1'b0;
      r_cur_addr <= '0;
      r_cur_wdata <= '0;
      r_a_rvalid <= 1'b0;
      r_a_err <= 1'b0;
      r_a_rdata <= '0;
      r_b_rvalid <= 1'b0;
      r_b_err <= 1'b0;
      r_b_rdata <= '0;
    end else begin
      r_state <= w_next;
      if (w_next != IDLE) r_last_b <= w_sel_b;
      r_cur_we <= w_we;
      r_cur_addr <= w_addr;
      r_cur_wdata <= w_wdata;
      r_cur_err <= w_addr > LAST_ADDR;
      r_a_rvalid <= w_a_resp;
      r_b_rvalid <= w_b_resp;
      if (w_a_resp) begin
        r_a_rdata <= r_cur_err ? '0 : bus.mem_rdata;
        r_a_err <= r_cur_err;
      end
      if (w_b_resp) begin
        r_b_rdata <= r_cur_err ? '0 : bus.mem_rdata;
        r_b_err <= r_cur_err;
      end
    end
  end
  assign bus.a_rvalid = r_a_rvalid;
  assign bus.a_err = r_a_err;
  assign bus.a_rdata = r_a_rdata;
  assign bus.b_rvalid = r_b_rvalid;
  assign bus.b_err = r_b_err;
  assign bus.b_rdata = r_b_rdata;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed self-checking bench with a behavioural 256-byte memory
module tb_dmem_arbiter;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic init_req = 1'b0;
  logic [7:0] mem [256];
  int checks = 0;
  int errors = 0;
  dmem_arbiter_if bus ();
  dmem_arbiter #(.MEM_BYTES(256)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (init_req) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'd0;
      mem[0] <= 8'd5;
      mem[8] <= 8'd10;
      mem[16] <= 8'd1;
    end else if (bus.mem_write) begin
      for (int i = 0; i < 8; i++) mem[bus.mem_addr[7:0] + 8'(i)] <= bus.mem_wdata[i*8 +: 8];
    end
  end
  always_comb begin
    bus.mem_rdata = '0;
    for (int i = 0; i < 8; i++) bus.mem_rdata[i*8 +: 8] = mem[bus.mem_addr[7:0] + 8'(i)];
  end
  function automatic logic [63:0] rd64(input int a);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < 8; i++) v[i*8 +: 8] = mem[(a + i) % 256];
    return v;
  endfunction
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    bus.a_req = 0; bus.a_we = 0; bus.a_addr = '0; bus.a_wdata = '0;
    bus.b_req = 0; bus.b_we = 0; bus.b_addr = '0; bus.b_wdata = '0;
    init_req = 1;
    tick();
    tick();
    chk("rst_a_gnt", 64'(bus.a_gnt), 0);
    chk("rst_b_gnt", 64'(bus.b_gnt), 0);
    chk("rst_a_rvalid", 64'(bus.a_rvalid), 0);
    chk("rst_a_rdata", bus.a_rdata, 0);
    chk("rst_mem_read", 64'(bus.mem_read), 0);
    init_req = 0;
    reset_n = 1;
    // load A addr 0
    bus.a_req = 1; bus.a_we = 0; bus.a_addr = 64'd0;
    tick();
    bus.a_req = 0;
    chk("t1_a_gnt", 64'(bus.a_gnt), 1);
    chk("t1_b_gnt", 64'(bus.b_gnt), 0);
    chk("t1_mem_read", 64'(bus.mem_read), 1);
    chk("t1_rvalid_early", 64'(bus.a_rvalid), 0);
    tick();
    chk("t1_a_rvalid", 64'(bus.a_rvalid), 1);
    chk("t1_a_rdata", bus.a_rdata, 64'd5);
    chk("t1_a_err", 64'(bus.a_err), 0);
    chk("t1_a_gnt_off", 64'(bus.a_gnt), 0);
    tick();
    chk("t1_rvalid_pulse", 64'(bus.a_rvalid), 0);
    chk("t1_rdata_hold", bus.a_rdata, 64'd5);
    // store B addr 8 then load A addr 8
    bus.b_req = 1; bus.b_we = 1; bus.b_addr = 64'd8; bus.b_wdata = 64'h1234;
    tick();
    chk("t2_b_gnt", 64'(bus.b_gnt), 1);
    chk("t2_mem_write", 64'(bus.mem_write), 1);
    chk("t2_mem_wdata", bus.mem_wdata, 64'h1234);
    bus.b_req = 0;
    bus.a_req = 1; bus.a_we = 0; bus.a_addr = 64'd8;
    tick();
    bus.a_req = 0;
    chk("t2_a_gnt", 64'(bus.a_gnt), 1);
    chk("t2_b_no_rvalid", 64'(bus.b_rvalid), 0);
    tick();
    chk("t2_a_rvalid", 64'(bus.a_rvalid), 1);
    chk("t2_a_rdata", bus.a_rdata, 64'h1234);
    chk("t2_mem8", rd64(8), 64'h1234);
    // reset so last_gnt is B again, then both ports request continuously
    reset_n = 0;
    tick();
    reset_n = 1;
    bus.a_req = 1; bus.a_we = 0; bus.a_addr = 64'd0;
    bus.b_req = 1; bus.b_we = 0; bus.b_addr = 64'd8;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("t3_a_gnt%0d", i), 64'(bus.a_gnt), 64'(i % 2 == 0));
      chk($sformatf("t3_b_gnt%0d", i), 64'(bus.b_gnt), 64'(i % 2 == 1));
    end
    bus.a_req = 0; bus.b_req = 0;
    tick();
    tick();
    // rejected store A addr 250
    bus.a_req = 1; bus.a_we = 1; bus.a_addr = 64'd250; bus.a_wdata = '1;
    tick();
    bus.a_req = 0;
    chk("t4_a_gnt", 64'(bus.a_gnt), 1);
    chk("t4_mem_write", 64'(bus.mem_write), 0);
    chk("t4_mem_read", 64'(bus.mem_read), 0);
    tick();
    chk("t4_a_rvalid", 64'(bus.a_rvalid), 1);
    chk("t4_a_err", 64'(bus.a_err), 1);
    chk("t4_a_rdata", bus.a_rdata, 0);
    chk("t4_mem_hi", 64'({mem[250], mem[251], mem[252], mem[253], mem[254], mem[255]}), 0);
    // store B addr 16 with reset asserted during its SERVE cycle
    bus.b_req = 1; bus.b_we = 1; bus.b_addr = 64'd16; bus.b_wdata = 64'd99;
    tick();
    bus.b_req = 0;
    chk("t5_b_gnt", 64'(bus.b_gnt), 1);
    reset_n = 0;
    #1;
    chk("t5_mem_write", 64'(bus.mem_write), 0);
    tick();
    reset_n = 1;
    chk("t5_b_rvalid", 64'(bus.b_rvalid), 0);
    chk("t5_b_gnt_off", 64'(bus.b_gnt), 0);
    chk("t5_a_err", 64'(bus.a_err), 0);
    chk("t5_b_rdata", bus.b_rdata, 0);
    chk("t5_mem16", rd64(16), 64'd1);
    tick();
    chk("t5_b_rvalid_late", 64'(bus.b_rvalid), 0);
    // back-to-back loads after reloading memory
    init_req = 1;
    tick();
    init_req = 0;
    bus.a_req = 1; bus.a_we = 0; bus.a_addr = 64'd0;
    tick();
    chk("t6_gnt0", 64'(bus.a_gnt), 1);
    bus.a_addr = 64'd8;
    tick();
    chk("t6_rvalid0", 64'(bus.a_rvalid), 1);
    chk("t6_rdata0", bus.a_rdata, 64'd5);
    bus.a_addr = 64'd16;
    tick();
    bus.a_req = 0;
    chk("t6_rvalid1", 64'(bus.a_rvalid), 1);
    chk("t6_rdata1", bus.a_rdata, 64'd10);
    tick();
    chk("t6_rvalid2", 64'(bus.a_rvalid), 1);
    chk("t6_rdata2", bus.a_rdata, 64'd1);
    tick();
    chk("t6_rvalid_end", 64'(bus.a_rvalid), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
